// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with its own bit timing from the system clock.
// Presents each good byte with a one-cycle valid strobe and mirrors its low nibble on the LEDs.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF         = CLKS_PER_BIT / 2 - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy,
    output logic [3:0] led
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [10:0] CNT_MAX  = 11'(CLKS_PER_BIT - 1);
    localparam logic [10:0] CNT_HALF = 11'(HALF);

    state_t      state, state_n;
    logic        sync1, rx_s;
    logic [10:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  rx_data_n;
    logic [3:0]  led_n;
    logic        valid_n, err_n;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            led          <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            rx_data      <= rx_data_n;
            led          <= led_n;
            rx_valid     <= valid_n;
            rx_frame_err <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        rx_data_n = rx_data;
        led_n     = led;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            // A start bit that is high again at mid-bit is a glitch.
            START: begin
                if (cnt != CNT_HALF) begin
                    cnt_n = cnt + 11'd1;
                end else if (!rx_s) begin
                    state_n   = DATA;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    shift_n = {rx_s, shift[7:1]};
                    cnt_n   = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            STOP: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rx_data_n = shift;
                        led_n     = shift[3:0];
                        valid_n   = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            // Hold off while the line is in a break so it cannot restart reception.
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: table of frame scenarios, hand-written corner
// sequences and random frames, all compared cycle by cycle against a frame-level model.
module tb_uart_rx_8n1;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2 - 1;
    localparam int MAXN = 1024;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [3:0] led;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .led          (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d0;
        logic       stop0;
        logic       two;
        logic [7:0] d1;
        int         hold_low;
        int         exp_valid_cnt;
        int         exp_err_cnt;
        logic [3:0] exp_led;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    string      seg_name;
    logic       wave      [0:MAXN-1];
    int         wave_len;
    logic       exp_valid [0:MAXN-1];
    logic       exp_err   [0:MAXN-1];
    logic       exp_busy  [0:MAXN-1];
    logic [7:0] exp_data  [0:MAXN-1];
    logic [7:0] vdata     [0:MAXN-1];
    int         seg_valid, seg_err, seg_busy, first_strobe;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_wave();
        wave_len = 0;
    endtask

    task automatic add_level(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            if (wave_len < MAXN) begin
                wave[wave_len] = lvl;
                wave_len++;
            end
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input logic stop);
        add_level(1'b0, CPB);
        for (int k = 0; k < 8; k++) add_level(d[k], CPB);
        add_level(stop, CPB);
    endtask

    // Synchronized line level seen by the receiver when it evaluates edge t.
    function automatic logic rs(input int t);
        if (t < 2) return 1'b1;
        if (t - 2 >= wave_len) return 1'b1;
        return wave[t-2];
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < MAXN) exp_busy[i] = 1'b1;
        end
    endtask

    // Frame-level reference: locate start edges, sample mid-bit points, classify the stop bit.
    task automatic build_model();
        int         t, m, ts;
        logic [7:0] sh;
        logic [7:0] last;
        for (int i = 0; i < MAXN; i++) begin
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
            exp_busy[i]  = 1'b0;
            vdata[i]     = 8'h00;
        end
        t = 0;
        while (t < wave_len) begin
            if (rs(t)) begin
                t++;
            end else begin
                m = t;
                if (rs(m + 1 + HALF)) begin
                    mark_busy(m, m + HALF);
                    t = m + 2 + HALF;
                end else begin
                    for (int k = 0; k < 8; k++) sh[k] = rs(m + 1 + HALF + (k + 1) * CPB);
                    ts = m + 1 + HALF + 9 * CPB;
                    mark_busy(m, ts - 1);
                    if (rs(ts)) begin
                        if (ts < MAXN) begin
                            exp_valid[ts] = 1'b1;
                            vdata[ts]     = sh;
                        end
                        t = ts + 1;
                    end else begin
                        if (ts < MAXN) exp_err[ts] = 1'b1;
                        mark_busy(ts, ts);
                        t = ts + 1;
                        while (t < wave_len + 2 && !rs(t)) begin
                            mark_busy(t, t);
                            t++;
                        end
                        t++;
                    end
                end
            end
        end
        last = 8'h00;
        for (int i = 0; i < MAXN; i++) begin
            if (exp_valid[i]) last = vdata[i];
            exp_data[i] = last;
        end
    endtask

    task automatic applyStimulus(input int n);
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        seg_valid    = 0;
        seg_err      = 0;
        seg_busy     = 0;
        first_strobe = -1;
        for (int i = 0; i < n; i++) begin
            uart_rx = wave[i];
            @(posedge clk);
            #1;
            if ((rx_valid || rx_frame_err) && first_strobe < 0) first_strobe = i;
            seg_valid += int'(rx_valid);
            seg_err   += int'(rx_frame_err);
            seg_busy  += int'(rx_busy);
            checkOutput($sformatf("%s c%0d {valid,err,busy,data,led}", seg_name, i),
                        {17'd0, rx_valid, rx_frame_err, rx_busy, rx_data, led},
                        {17'd0, exp_valid[i], exp_err[i], exp_busy[i], exp_data[i], exp_data[i][3:0]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [5];
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'h00, 0,  1, 0, 4'h5};
        vecs[1] = '{8'h0F, 1'b1, 1'b1, 8'h03, 0,  2, 0, 4'h3};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 8'h3C, 20, 1, 1, 4'hC};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 0,  1, 0, 4'h0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 5,  0, 1, 4'h0};

        // Reset held with an idle line: everything reads 0.
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", {17'd0, rx_valid, rx_frame_err, rx_busy, rx_data, led}, 32'd0);

        seg_name = "idle";
        clear_wave();
        add_level(1'b1, 30);
        build_model();
        applyStimulus(wave_len);
        checkOutput("idle busy cycles", seg_busy, 0);

        for (int v = 0; v < 5; v++) begin
            seg_name = $sformatf("vec%0d", v);
            clear_wave();
            add_level(1'b1, 3);
            add_frame(vecs[v].d0, vecs[v].stop0);
            if (!vecs[v].stop0) add_level(1'b0, vecs[v].hold_low);
            if (vecs[v].two) begin
                if (!vecs[v].stop0) add_level(1'b1, 4);
                add_frame(vecs[v].d1, 1'b1);
            end
            add_level(1'b1, 12);
            build_model();
            applyStimulus(wave_len);
            checkOutput({seg_name, " valid count"}, seg_valid, vecs[v].exp_valid_cnt);
            checkOutput({seg_name, " err count"}, seg_err, vecs[v].exp_err_cnt);
            checkOutput({seg_name, " led"}, {28'd0, led}, {28'd0, vecs[v].exp_led});
            checkOutput({seg_name, " first strobe cycle"}, first_strobe, 3 + 40);
        end

        // Glitch after a good byte: short busy blip, no new strobe, byte kept.
        seg_name = "glitch";
        clear_wave();
        add_level(1'b1, 3);
        add_frame(8'h5A, 1'b1);
        add_level(1'b1, 6);
        add_level(1'b0, 1);
        add_level(1'b1, 20);
        build_model();
        applyStimulus(wave_len);
        checkOutput("glitch valid count", seg_valid, 1);
        checkOutput("glitch busy cycles", seg_busy, 40);
        checkOutput("glitch rx_data kept", {24'd0, rx_data}, 32'h5A);

        // Reset during data bit 4 of 0xFF, then a full 0x81 frame.
        seg_name = "midreset";
        clear_wave();
        add_level(1'b1, 3);
        add_frame(8'hFF, 1'b1);
        add_level(1'b1, 10);
        build_model();
        applyStimulus(3 + 22);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset outputs", {17'd0, rx_valid, rx_frame_err, rx_busy, rx_data, led}, 32'd0);
        checkOutput("midreset valid count", seg_valid, 0);

        seg_name = "after_reset";
        clear_wave();
        add_level(1'b1, 3);
        add_frame(8'h81, 1'b1);
        add_level(1'b1, 12);
        build_model();
        applyStimulus(wave_len);
        checkOutput("after_reset valid count", seg_valid, 1);
        checkOutput("after_reset rx_data", {24'd0, rx_data}, 32'h81);
        checkOutput("after_reset first strobe cycle", first_strobe, 3 + 40);

        // Random frame trains with occasional framing errors and breaks.
        for (int r = 0; r < 8; r++) begin
            seg_name = $sformatf("rand%0d", r);
            clear_wave();
            add_level(1'b1, int'($urandom_range(1, 5)));
            for (int f = 0; f < 3; f++) begin
                logic stop;
                stop = ($urandom_range(0, 3) != 0);
                add_frame(8'($urandom_range(0, 255)), stop);
                if (!stop) begin
                    add_level(1'b0, int'($urandom_range(0, 8)));
                    add_level(1'b1, int'($urandom_range(1, 4)));
                end else begin
                    add_level(1'b1, int'($urandom_range(0, 4)));
                end
            end
            add_level(1'b1, 15);
            build_model();
            applyStimulus(wave_len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Receive-side counterpart of the 8N1 UART transmit path: deserializes bytes arriving on the board's UART RX pin, validates framing, and presents each good byte with a one-cycle valid strobe. It also latches the low nibble of the last good byte onto four LED outputs, so the board can display switch states sent by a peer transmitting `{4'b0000, sw1..sw4}`. The block runs directly from the system clock and does its own bit timing, with no external baud clock.

## Interface
- `CLKS_PER_BIT`, default 1250, is the number of `clk` cycles per bit (12 MHz / 9600 baud). It must be ≥ 4.
- `HALF`, default `CLKS_PER_BIT/2 - 1`, is the start-bit mid-sample count. It is derived and must not be overridden.
- `clk`: input, 1 bit. System clock.
- `rst`: input, 1 bit. Reset, asynchronous and active-high.
- `uart_rx`: input, 1 bit. Serial line, idle high, LSB first, 8N1.
- `rx_data`: output, 8 bits. Last good byte, held until the next good byte.
- `rx_valid`: output, 1 bit. One-cycle pulse when `rx_data` updates.
- `rx_frame_err`: output, 1 bit. One-cycle pulse when the stop bit is sampled low.
- `rx_busy`: output, 1 bit. High whenever the state is not IDLE.
- `led`: output, 4 bits. Equals `rx_data[3:0]` and updates together with `rx_data`.

## Operation
- **Synchronizer:** `uart_rx` passes through two flops to produce `rx_s`. Both flops reset to 1.
- **Counters:**
  - `cnt` is 11 bits and sized for `CLKS_PER_BIT-1`.
  - `bit_idx` is 3 bits.
  - `shift` is 8 bits. Incoming bits enter at bit 7 and shift right, so the first received bit ends up in `shift[0]`.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** when `rx_s==0`, go to START with `cnt=0`.
  - **START:**
    - If `cnt!=HALF`, increment `cnt`.
    - At `cnt==HALF`, if `rx_s==0`, go to DATA with `cnt=0` and `bit_idx=0`.
    - At `cnt==HALF`, if `rx_s==1`, treat it as a glitch and return to IDLE with no flags raised.
  - **DATA:**
    - At `cnt==CLKS_PER_BIT-1`, shift `rx_s` into `shift` and set `cnt=0`. If `bit_idx==7`, go to STOP; otherwise increment `bit_idx`.
    - On all other cycles, increment `cnt`.
  - **STOP:** at `cnt==CLKS_PER_BIT-1`:
    - If `rx_s==1`, set `rx_data<=shift` and `led<=shift[3:0]`, pulse `rx_valid`, and go to IDLE.
    - If `rx_s==0`, pulse `rx_frame_err`, leave `rx_data` and `led` unchanged, and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s==1`, then go to IDLE. This prevents a break condition (line held low) from restarting reception.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- Each pulse lasts exactly one cycle; nothing holds it high.
- **Reset:** asynchronous `rst` at any point, including mid-frame, forces the following, with no partial byte emitted:
  - state IDLE;
  - `cnt`, `bit_idx` and `shift` to 0;
  - `rx_data`, `led`, `rx_valid`, `rx_frame_err` and `rx_busy` to 0;
  - synchronizer flops to 1.

## Timing
- Let E be the first `clk` edge at which `uart_rx` is sampled 0.
- `rx_s` goes low after edge E+1. The state becomes START at edge E+2.
- The start bit is confirmed at edge E+3+HALF.
- Data bit k (k=0..7) is sampled at edge E+3+HALF+(k+1)·`CLKS_PER_BIT`.
- The stop bit is sampled at edge E+3+HALF+9·`CLKS_PER_BIT`. `rx_valid` or `rx_frame_err` is high for the single cycle following that edge.
- With `CLKS_PER_BIT=4` (HALF=1), the strobe is high after edge E+40.
- `rx_busy` rises after edge E+2.
  - On a good frame it falls after the stop-sample edge.
  - On a frame error it falls one edge after `rx_s` returns high.
- Back-to-back frames, where the next start bit immediately follows the stop bit, are received without loss. IDLE detects the new start edge on the first cycle after the stop sample.
- A low pulse shorter than HALF+1 cycles at the synchronizer output is rejected as a glitch.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
- Reset: hold `rst`=1 with `uart_rx` idle high. Required: all outputs 0; after release, `rx_busy` stays 0.
- Single byte 0xA5: `rx_valid` pulses exactly once, at E+40, with `rx_data`=0xA5, `led`=4'b0101 and `rx_frame_err` never asserted.
- Two frames 0x0F then 0x03, back-to-back with no idle gap: `rx_valid` pulses twice, 40 cycles apart; `led` reads 4'hF and then 4'h3.
- Glitch: drive `uart_rx` low for 1 cycle, then high. Required: `rx_busy` pulses high then returns to IDLE; no `rx_valid`; `rx_data` unchanged.
- Framing error: send 0x55 with the stop bit low, then hold the line low for 20 cycles, then raise it. Required:
  - `rx_frame_err` pulses once and `rx_data`/`led` keep their prior values;
  - `rx_busy` stays high until the line goes high;
  - a following good byte 0x3C then yields `rx_valid` and `led`=4'hC.
- Mid-frame reset: assert `rst` during data bit 4 of 0xFF. Required: outputs return to 0 immediately and no `rx_valid` occurs; the next full frame 0x81 is received correctly.
